snr_sweep_ctrl: RTL and testbench

Sequencer for the channel's noise-scale input. It replaces hand-stepped bench phases (clean / low noise / high noise) with a programmable schedule: up to `MAX_STEPS` entries of (sigma value, symbol count), driven onto the AWGN block's `sigma_scale` input. After each change it blanks measurement while the channel pipeline settles, then counts qualified symbols. It sits beside `top`, between the register/bench side and the noise-generator scale port.

---
 rtl/snr_sweep_pkg.sv | 25 ++
 rtl/sweep_step_table.sv | 48 ++++
 rtl/snr_sweep_ctrl.sv | 175 +++++++++++++++++
 tb/tb_snr_sweep_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snr_sweep_pkg.sv
// ============================================================================
// Module   : snr_sweep_pkg
// Brief    : Shared types and default widths for the SNR sweep sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package snr_sweep_pkg;

    localparam int DEF_SNR_WIDTH  = 11;
    localparam int DEF_LEN_WIDTH  = 16;
    localparam int DEF_MAX_STEPS  = 8;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_IDX_WIDTH  = $clog2(DEF_MAX_STEPS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } sweep_state_t;

endpackage

`default_nettype wire

// File: rtl/sweep_step_table.sv
// ============================================================================
// Module   : sweep_step_table
// Brief    : Schedule register file; writes blocked while a sweep is busy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_step_table
    import snr_sweep_pkg::*;
#(
    parameter int SNR_WIDTH = DEF_SNR_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int MAX_STEPS = DEF_MAX_STEPS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_we,
    input  logic                         i_busy,
    input  logic [$clog2(MAX_STEPS)-1:0] i_waddr,
    input  logic [SNR_WIDTH-1:0]         i_wsigma,
    input  logic [LEN_WIDTH-1:0]         i_wlen,
    input  logic [$clog2(MAX_STEPS)-1:0] i_raddr_cur,
    output logic [LEN_WIDTH-1:0]         o_len_cur,
    input  logic [$clog2(MAX_STEPS)-1:0] i_raddr_nxt,
    output logic [SNR_WIDTH-1:0]         o_sigma_nxt
);

    logic [SNR_WIDTH-1:0] r_sigma [MAX_STEPS];
    logic [LEN_WIDTH-1:0] r_len   [MAX_STEPS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_STEPS; i++) begin
                r_sigma[i] <= '0;
                r_len[i]   <= '0;
            end
        end else if (i_we && !i_busy) begin
            r_sigma[i_waddr] <= i_wsigma;
            r_len[i_waddr]   <= i_wlen;
        end
    end

    assign o_len_cur   = r_len[i_raddr_cur];
    assign o_sigma_nxt = r_sigma[i_raddr_nxt];

endmodule

`default_nettype wire

// File: rtl/snr_sweep_ctrl.sv
// ============================================================================
// Module   : snr_sweep_ctrl
// Brief    : Steps the channel sigma through a programmed schedule, blanking
//            measurement for a settle window after every sigma change.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snr_sweep_ctrl
    import snr_sweep_pkg::*;
#(
    parameter int SNR_WIDTH  = DEF_SNR_WIDTH,
    parameter int MAX_STEPS  = DEF_MAX_STEPS,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(MAX_STEPS)-1:0] cfg_addr,
    input  logic [SNR_WIDTH-1:0]         cfg_sigma,
    input  logic [LEN_WIDTH-1:0]         cfg_len,
    input  logic [$clog2(MAX_STEPS):0]   num_steps,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         sym_en,
    output logic [SNR_WIDTH-1:0]         sigma_scale,
    output logic                         meas_en,
    output logic [$clog2(MAX_STEPS)-1:0] step_idx,
    output logic                         step_start,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted
);

    localparam int C_IDX_W = $clog2(MAX_STEPS);
    localparam int C_SET_W = $clog2(SETTLE_CYC + 1);

    sweep_state_t         r_state, w_state_nxt;
    logic [SNR_WIDTH-1:0] r_sigma, w_sigma_nxt, w_sigma_tbl;
    logic [C_IDX_W-1:0]   r_idx, w_idx_nxt, w_nxt_addr;
    logic [C_IDX_W:0]     r_num, w_num_nxt, w_num_clamp, w_idx_p1;
    logic [C_SET_W-1:0]   r_settle, w_settle_nxt;
    logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt, w_len_cur, w_len_eff;
    logic                 r_step_start, w_step_start_nxt;
    logic                 r_aborted, w_aborted_nxt;
    logic                 w_busy, w_sym_last, w_settle_last;

    sweep_step_table #(
        .SNR_WIDTH (SNR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .MAX_STEPS (MAX_STEPS)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .i_we        (cfg_we),
        .i_busy      (w_busy),
        .i_waddr     (cfg_addr),
        .i_wsigma    (cfg_sigma),
        .i_wlen      (cfg_len),
        .i_raddr_cur (r_idx),
        .o_len_cur   (w_len_cur),
        .i_raddr_nxt (w_nxt_addr),
        .o_sigma_nxt (w_sigma_tbl)
    );

    assign w_busy        = (r_state == S_SETTLE) || (r_state == S_MEASURE);
    assign w_idx_p1      = {1'b0, r_idx} + (C_IDX_W + 1)'(1);
    // In IDLE the lookahead port fetches entry 0; otherwise the next entry.
    assign w_nxt_addr    = (r_state == S_IDLE) ? '0 : w_idx_p1[C_IDX_W-1:0];
    assign w_num_clamp   = (num_steps > (C_IDX_W + 1)'(MAX_STEPS)) ?
                           (C_IDX_W + 1)'(MAX_STEPS) : num_steps;
    assign w_len_eff     = (w_len_cur == '0) ? LEN_WIDTH'(1) : w_len_cur;
    assign w_sym_last    = sym_en && (r_cnt == w_len_eff - LEN_WIDTH'(1));
    assign w_settle_last = (r_settle == C_SET_W'(SETTLE_CYC - 1));

    always_comb begin
        w_state_nxt      = r_state;
        w_sigma_nxt      = r_sigma;
        w_idx_nxt        = r_idx;
        w_num_nxt        = r_num;
        w_settle_nxt     = r_settle;
        w_cnt_nxt        = r_cnt;
        w_step_start_nxt = 1'b0;
        w_aborted_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_num_nxt = w_num_clamp;
                    w_idx_nxt = '0;
                    if (num_steps == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt      = S_SETTLE;
                        w_sigma_nxt      = w_sigma_tbl;
                        w_step_start_nxt = 1'b1;
                        w_settle_nxt     = '0;
                    end
                end
            end
            S_SETTLE: begin
                if (w_settle_last) begin
                    w_state_nxt = S_MEASURE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_settle_nxt = r_settle + C_SET_W'(1);
                end
            end
            S_MEASURE: begin
                if (w_sym_last) begin
                    if (w_idx_p1 < r_num) begin
                        w_state_nxt      = S_SETTLE;
                        w_idx_nxt        = w_idx_p1[C_IDX_W-1:0];
                        w_sigma_nxt      = w_sigma_tbl;
                        w_step_start_nxt = 1'b1;
                        w_settle_nxt     = '0;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_sigma_nxt = '0;
                        w_idx_nxt   = '0;
                    end
                end else if (sym_en) begin
                    w_cnt_nxt = r_cnt + LEN_WIDTH'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort overrides any same-cycle step completion.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt      = S_IDLE;
            w_sigma_nxt      = '0;
            w_idx_nxt        = '0;
            w_step_start_nxt = 1'b0;
            w_aborted_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_sigma      <= '0;
            r_idx        <= '0;
            r_num        <= '0;
            r_settle     <= '0;
            r_cnt        <= '0;
            r_step_start <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sigma      <= w_sigma_nxt;
            r_idx        <= w_idx_nxt;
            r_num        <= w_num_nxt;
            r_settle     <= w_settle_nxt;
            r_cnt        <= w_cnt_nxt;
            r_step_start <= w_step_start_nxt;
            r_aborted    <= w_aborted_nxt;
        end
    end

    assign sigma_scale = r_sigma;
    assign step_idx    = r_idx;
    assign step_start  = r_step_start;
    assign aborted     = r_aborted;
    assign busy        = w_busy;
    assign meas_en     = sym_en && (r_state == S_MEASURE);
    assign done        = (r_state == S_DONE) && !abort;

endmodule

`default_nettype wire

// File: tb/tb_snr_sweep_ctrl.sv
// ============================================================================
// Module   : tb_snr_sweep_ctrl
// Brief    : Directed, table-driven bench for the SNR sweep sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snr_sweep_ctrl;

    localparam logic [10:0] C_NEG5 = 11'h7FB;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [10:0] cfg_sigma;
    logic [15:0] cfg_len;
    logic [3:0]  num_steps;
    logic        start;
    logic        abort;
    logic        sym_en;
    logic [10:0] sigma_scale;
    logic        meas_en;
    logic [2:0]  step_idx;
    logic        step_start;
    logic        busy;
    logic        done;
    logic        aborted;

    int n_asrt;
    int n_fail;

    snr_sweep_ctrl #(
        .SNR_WIDTH  (11),
        .MAX_STEPS  (8),
        .LEN_WIDTH  (16),
        .SETTLE_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_sigma   (cfg_sigma),
        .cfg_len     (cfg_len),
        .num_steps   (num_steps),
        .start       (start),
        .abort       (abort),
        .sym_en      (sym_en),
        .sigma_scale (sigma_scale),
        .meas_en     (meas_en),
        .step_idx    (step_idx),
        .step_start  (step_start),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int k;
        int sig;
        int bsy;
        int ss;
        int dn;
        int me;
        int idx;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input int act, input int exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [10:0] s, input int l);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(a);
        cfg_sigma = s;
        cfg_len   = 16'(l);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic start_run(input int n);
        num_steps = 4'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Returns the observation index (edges since start) at which done is seen.
    task automatic wait_done(input int k0, output int kd);
        int k;
        k = k0;
        while (!done && (k < k0 + 400)) begin
            tick();
            k++;
        end
        kd = k;
    endtask

    initial begin
        int n_ss, n_me, n_dn, vi, q, last, kd;

        n_asrt = 0;
        n_fail = 0;
        rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_sigma = '0; cfg_len = '0;
        num_steps = '0; start = 1'b0; abort = 1'b0; sym_en = 1'b0;

        // Expected waveform for a 3-step sweep {0,10},{200,10},{800,10}.
        vt[0]  = '{0,  0,   1, 1, 0, 0, 0};
        vt[1]  = '{1,  0,   1, 0, 0, 0, 0};
        vt[2]  = '{15, 0,   1, 0, 0, 0, 0};
        vt[3]  = '{16, 0,   1, 0, 0, 1, 0};
        vt[4]  = '{25, 0,   1, 0, 0, 1, 0};
        vt[5]  = '{26, 200, 1, 1, 0, 0, 1};
        vt[6]  = '{42, 200, 1, 0, 0, 1, 1};
        vt[7]  = '{52, 800, 1, 1, 0, 0, 2};
        vt[8]  = '{77, 800, 1, 0, 0, 1, 2};
        vt[9]  = '{78, 0,   0, 0, 1, 0, 0};
        vt[10] = '{79, 0,   0, 0, 0, 0, 0};

        #2;
        chk("rst_sigma", int'(sigma_scale), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_step_start", int'(step_start), 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // ---------------- three-step sweep ----------------
        wr(0, 11'd0, 10);
        wr(1, 11'd200, 10);
        wr(2, 11'd800, 10);
        sym_en = 1'b1;
        start_run(3);
        n_ss = 0; n_me = 0; n_dn = 0; vi = 0;
        for (int k = 0; k <= 80; k++) begin
            n_ss += int'(step_start);
            n_me += int'(meas_en);
            n_dn += int'(done);
            if (vi < 11 && vt[vi].k == k) begin
                chk($sformatf("sweep_sigma@%0d", k), int'(sigma_scale), vt[vi].sig);
                chk($sformatf("sweep_busy@%0d", k), int'(busy), vt[vi].bsy);
                chk($sformatf("sweep_step_start@%0d", k), int'(step_start), vt[vi].ss);
                chk($sformatf("sweep_done@%0d", k), int'(done), vt[vi].dn);
                chk($sformatf("sweep_meas_en@%0d", k), int'(meas_en), vt[vi].me);
                chk($sformatf("sweep_idx@%0d", k), int'(step_idx), vt[vi].idx);
                vi++;
            end
            tick();
        end
        chk("sweep_step_start_count", n_ss, 3);
        chk("sweep_meas_en_count", n_me, 30);
        chk("sweep_done_count", n_dn, 1);

        // ---------------- sparse symbols, one entry ----------------
        sym_en = 1'b0;
        wr(0, 11'd200, 5);
        start_run(1);
        chk("sparse_sigma", int'(sigma_scale), 200);
        q = 0; last = -1; kd = -1;
        for (int k = 0; k < 200 && kd < 0; k++) begin
            sym_en = ((k % 4) == 3);
            #1;
            if (meas_en) begin
                q++;
                if (q == 5) last = k;
            end
            tick();
            if (done) kd = k + 1;
        end
        sym_en = 1'b0;
        chk("sparse_meas_count", q, 5);
        chk("sparse_last_sym", last, 35);
        chk("sparse_done_at", kd, 36);
        chk("sparse_busy_at_done", int'(busy), 0);
        tick();

        // ---------------- abort on final symbol of step 1 ----------------
        wr(0, 11'd0, 10);
        sym_en = 1'b1;
        start_run(3);
        for (int k = 0; k < 51; k++) tick();
        chk("abort_pre_idx", int'(step_idx), 1);
        chk("abort_pre_meas", int'(meas_en), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_aborted", int'(aborted), 1);
        chk("abort_done", int'(done), 0);
        chk("abort_sigma", int'(sigma_scale), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_step_start", int'(step_start), 0);
        tick();
        chk("abort_pulse_end", int'(aborted), 0);
        chk("abort_idle_done", int'(done), 0);

        // ---------------- zero-step start ----------------
        sym_en = 1'b0;
        start_run(0);
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 0);
        chk("zero_sigma", int'(sigma_scale), 0);
        tick();
        chk("zero_done_end", int'(done), 0);
        chk("zero_busy_after", int'(busy), 0);

        // ---------------- write while busy ----------------
        sym_en = 1'b1;
        start_run(1);
        tick(); tick();
        wr(0, C_NEG5, 7);
        wait_done(3, kd);
        chk("blocked_run_done_at", kd, 26);
        tick();
        start_run(1);
        chk("blocked_sigma_kept", int'(sigma_scale), 0);
        wait_done(0, kd);
        chk("blocked_len_kept", kd, 26);
        wr(0, C_NEG5, 7);
        start_run(1);
        chk("write_after_done_sigma", int'(sigma_scale), int'(C_NEG5));
        wait_done(0, kd);
        chk("write_after_done_len", kd, 23);
        tick();

        // ---------------- reset mid-SETTLE ----------------
        start_run(3);
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b0;
        #2;
        chk("midrst_sigma", int'(sigma_scale), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_step_start", int'(step_start), 0);
        chk("midrst_idx", int'(step_idx), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_aborted", int'(aborted), 0);
        chk("midrst_meas_en", int'(meas_en), 0);
        tick();
        rst = 1'b1;
        tick();
        start_run(2);
        chk("postrst_sigma", int'(sigma_scale), 0);
        chk("postrst_idx", int'(step_idx), 0);
        wait_done(0, kd);
        chk("postrst_done_at", kd, 34);
        tick();

        // num_steps above MAX_STEPS is clamped to 8 single-symbol steps.
        start_run(15);
        wait_done(0, kd);
        chk("clamp_done_at", kd, 136);
        tick();
        chk("clamp_idle_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
